// File: rtl/pl_data_mem_responder_pkg.sv
// Shared definitions for the load/store memory responder: func3 size codes and FSM states.
package pl_mem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) ||
           (size == SIZE_BU) || (size == SIZE_HU);
  endfunction

endpackage

// File: rtl/pl_data_mem_responder_if.sv
// Request/response channel between the core's load/store unit (master) and the memory responder (slave).
interface pl_data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/pl_data_mem_responder_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the way in,
// lane extraction with sign/zero extension on the way out.
module pl_mem_lane_align
  import pl_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      SIZE_B, SIZE_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H, SIZE_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      SIZE_W: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (size)
      SIZE_B:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_BU: rdata = {24'h0, shifted[7:0]};
      SIZE_H:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_HU: rdata = {16'h0, shifted[15:0]};
      SIZE_W:  rdata = shifted;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/pl_data_mem_responder.sv
// Multi-cycle data memory: one request at a time, fixed response latency, byte-enabled word array.
module pl_data_mem_responder
  import pl_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                   clk,
  input logic                   rst,
  pl_data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_size;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic        busy_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_data;
  logic             misalign;
  logic             out_of_range;
  logic             err;
  logic             finish_wait;
  logic             commit;

  assign idx          = lat_addr[IDX_W+1:2];
  assign out_of_range = lat_addr[31:2] >= 30'(DEPTH_WORDS);
  assign err          = misalign | ~size_legal(lat_size) | out_of_range;
  assign finish_wait  = (state == WAIT) && (cnt == 4'd0);
  assign commit       = finish_wait && lat_we && !err;

  pl_mem_lane_align u_align (
    .size      (lat_size),
    .addr_lo   (lat_addr[1:0]),
    .wdata     (lat_wdata),
    .word      (mem[idx]),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata     (load_data),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            lat_size    <= bus.req_size;
            cnt         <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err;
            resp_rdata_q <= (err || lat_we) ? 32'h0 : load_data;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The array has no reset, so a reset during WAIT simply means commit never fires.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

endmodule
